y86_seq_controller: RTL and testbench
=====================================

# y86_seq_controller

Multi-cycle control unit for the Y86 datapath. It replaces single-cycle combinational decode with a registered state machine. It sequences each instruction through fetch, execute, memory and write-back, and adds memory access with a timeout. It also holds the condition-code register, evaluates conditional moves and jumps, and reports processor status. It sits between the fetch/instruction register and the register file, ALU, data memory port and PC update logic.

## Interface
- `ADDR_W`, default 32: PC/address width; sizes nothing internally, kept for datapath consistency checks.
- `TIMEOUT_CYCLES`, default 255, ≥1: MEM cycles with `mem_ready` low before ADR error.
- `clk` in 1: single clock; all state on rising edge.
- `reset_n` in 1: reset is asynchronous and active-low.
- `icode`, `ifun`, `rA`, `rB` in 4 each: fields of the offered instruction, valid while `instr_valid`.
- `instr_valid` in 1: fetch offers an instruction.
- `instr_ready` out 1: controller accepts; transfer on `instr_valid & instr_ready`.
- `alu_zf`, `alu_sf`, `alu_of` in 1: ALU flags of the current EXEC cycle.
- `mem_ready` in 1: data memory completes the access this cycle.
- `srcA`, `srcB` out 4: latched rA/rB.
- `dstE`, `dstM` out 4: write-back register ids; 0xF = none.
- `reg_we_e`, `reg_we_m` out 1: register-file write strobes.
- `aluASelect` out 1: 0 RegA, 1 ValC.
- `aluBSelect` out 1: 0 RegB, 1 Zero.
- `alufun` out 2: 0 ADD, 1 SUB, 2 AND, 3 XOR.
- `mem_rd`, `mem_wr` out 1: memory request strobes.
- `pc_we` out 1: PC update strobe.
- `pc_sel` out 1: 0 valP, 1 valC (jump taken).
- `cc` out 3: {ZF,SF,OF}.
- `stat` out 2: 0 AOK, 1 HLT, 2 ADR, 3 INS.
- `halt` out 1: high only in STOP.

## Operation
- States: FETCH, EXEC, MEM, WB, STOP. Instruction fields are latched on acceptance; all outputs decode from the state and the latched fields.
- FETCH: `instr_ready`=1. On acceptance:
  - icode 0 (HALT) → STOP, stat=HLT.
  - Illegal → STOP, stat=INS. Illegal means: icode ∉ {0,1,2,3,4,5,6,7}; OPl with ifun>3; rrmovl/jXX with ifun>6; irmovl/rmmovl/mrmovl with ifun≠0.
  - Otherwise → EXEC.
- EXEC (1 cycle); ALU controls per icode:
  - NOP: none.
  - rrmovl/cmovXX: A=RegA, B=Zero, fun XOR.
  - irmovl: A=ValC, B=Zero, fun XOR.
  - rmmovl/mrmovl: A=ValC, B=RegB, fun ADD.
  - OPl: A=RegA, B=RegB, fun=ifun[1:0]; `cc` loads {alu_zf,alu_sf,alu_of} at the end of this cycle.
  - jXX: ALU unused.
  - Condition `cnd` is evaluated from `cc` here and latched.
  - Next state: MEM for rmmovl/mrmovl, else WB.
- Conditions by ifun: 0 always; 1 le = (SF^OF)|ZF; 2 l = SF^OF; 3 e = ZF; 4 ne = ~ZF; 5 ge = ~(SF^OF); 6 g = ~(SF^OF)&~ZF.
- MEM: `mem_wr` (rmmovl) or `mem_rd` (mrmovl) is held high every MEM cycle.
  - `mem_ready`=1 → WB.
  - Otherwise the wait counter increments. At count = TIMEOUT_CYCLES → STOP, stat=ADR, strobes drop.
  - Counter clears on MEM entry.
- WB (1 cycle): `pc_we`=1 always.
  - rrmovl: dstE=rB and `reg_we_e`=1 only if `cnd` (cmov not taken → dstE=0xF, no write).
  - irmovl/OPl: dstE=rB, `reg_we_e`=1.
  - mrmovl: dstM=rA, `reg_we_m`=1.
  - jXX: `pc_sel`=cnd.
  - Next state FETCH.
- STOP: absorbing; `halt`=1, `instr_ready`=0, all strobes 0; only reset exits.
- Outside their designated cycles, strobes are 0, dstE/dstM are 0xF, and selects/alufun are 0.

## Timing
- Reset (asynchronous, immediate, any state including mid-MEM): state FETCH, `instr_ready`=1, cc=3'b100, stat=AOK, halt=0, strobes 0, dstE=dstM=0xF, srcA=srcB=0, selects 0, alufun 0, pc_sel 0, wait counter 0.
- Latency from acceptance edge: non-memory instruction = EXEC + WB, next accept 3 cycles after previous accept. Memory instruction = EXEC + (1+w) MEM + WB, where w = cycles with `mem_ready` low.
- `mem_ready` is sampled in the same cycle as the strobe; zero-wait completes MEM in one cycle.
- ADR timeout: STOP entered on the edge ending the TIMEOUT_CYCLES-th consecutive not-ready MEM cycle.
- OPl followed immediately by jXX/cmov sees the updated `cc` (loaded at OPl EXEC end, read at the next instruction's EXEC).
- `instr_valid` is ignored outside FETCH; fetch must hold the fields until accepted.

## Test plan
- Reset: assert `reset_n`=0 during MEM of mrmovl with `mem_ready`=0 → next sample: mem_rd=0, instr_ready=1, cc=100, stat=0, halt=0.
- irmovl rB=3 → EXEC aluASelect=1, aluBSelect=1, alufun=3. WB dstE=3, reg_we_e=1, pc_we=1. Next acceptance 3 cycles after the first.
- subl (6,1) with alu_zf=1 → cc=100. Then je (7,3) → WB pc_sel=1; jne (7,4) → pc_sel=0. cmovne (2,4) rB=5 → dstE=0xF, reg_we_e=0.
- mrmovl rA=2, rB=4 with `mem_ready` low 2 cycles → aluASelect=1, aluBSelect=0, alufun=0. mem_rd held 3 cycles. WB dstM=2, reg_we_m=1.
- rmmovl with TIMEOUT_CYCLES=4, `mem_ready` never high → mem_wr high exactly 4 cycles, then stat=2, halt=1. instr_valid is ignored afterward.
- icode 0x0 → stat=1, halt=1, pc_we never pulsed. icode 0xC → stat=3. OPl ifun 5 → stat=3. jXX ifun 7 → stat=3.

Source files
------------

// File: rtl/y86_seq_controller.sv
// Multi-cycle Y86 control unit: FETCH/EXEC/MEM/WB/STOP sequencer with
// condition codes, cmov/jump evaluation, memory timeout and status.
// Outputs are registered: each edge loads the decode of the state being entered.
module y86_seq_controller #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] icode,
  input  logic [3:0] ifun,
  input  logic [3:0] rA,
  input  logic [3:0] rB,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic       alu_zf,
  input  logic       alu_sf,
  input  logic       alu_of,
  input  logic       mem_ready,
  output logic [3:0] srcA,
  output logic [3:0] srcB,
  output logic [3:0] dstE,
  output logic [3:0] dstM,
  output logic       reg_we_e,
  output logic       reg_we_m,
  output logic       aluASelect,
  output logic       aluBSelect,
  output logic [1:0] alufun,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       pc_we,
  output logic       pc_sel,
  output logic [2:0] cc,
  output logic [1:0] stat,
  output logic       halt
);
  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_WB, S_STOP} st_t;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  st_t          st, st_n;
  logic [3:0]   ic_q, fn_q, ic_n, fn_n, ra_n, rb_n;
  logic         cnd_q, cnd_n;
  logic [2:0]   cc_n;
  logic [1:0]   stat_n;
  logic [CW-1:0] wcnt, wcnt_n;
  logic         rdy_n, we_e_n, we_m_n, as_n, bs_n, rd_n, wr_n, pw_n, ps_n, hlt_n;
  logic [3:0]   de_n, dm_n;
  logic [1:0]   fn_alu_n;
  logic         illegal;

  // Y86 condition table over {ZF,SF,OF}
  function automatic logic cond(input logic [3:0] f, input logic [2:0] c);
    logic z, s, o;
    {z, s, o} = c;
    case (f)
      4'd0:    cond = 1'b1;
      4'd1:    cond = (s ^ o) | z;
      4'd2:    cond = s ^ o;
      4'd3:    cond = z;
      4'd4:    cond = ~z;
      4'd5:    cond = ~(s ^ o);
      4'd6:    cond = ~(s ^ o) & ~z;
      default: cond = 1'b0;
    endcase
  endfunction

  // classify the offered instruction
  always_comb begin
    illegal = 1'b0;
    case (icode)
      4'h0, 4'h1:       illegal = 1'b0;
      4'h2, 4'h7:       illegal = (ifun > 4'd6);
      4'h3, 4'h4, 4'h5: illegal = (ifun != 4'd0);
      4'h6:             illegal = (ifun > 4'd3);
      default:          illegal = 1'b1;
    endcase
  end

  // next state and next architectural state
  always_comb begin
    st_n = st; ic_n = ic_q; fn_n = fn_q; ra_n = srcA; rb_n = srcB;
    cnd_n = cnd_q; cc_n = cc; stat_n = stat; wcnt_n = wcnt;
    case (st)
      S_FETCH: if (instr_valid) begin
        ic_n = icode; fn_n = ifun; ra_n = rA; rb_n = rB;
        if (icode == 4'h0)  begin st_n = S_STOP; stat_n = 2'd1; end
        else if (illegal)   begin st_n = S_STOP; stat_n = 2'd3; end
        else                st_n = S_EXEC;
      end
      S_EXEC: begin
        cnd_n  = cond(fn_q, cc);
        if (ic_q == 4'h6) cc_n = {alu_zf, alu_sf, alu_of};
        wcnt_n = '0;
        st_n   = (ic_q == 4'h4 || ic_q == 4'h5) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (mem_ready) st_n = S_WB;
        else if (wcnt == CW'(TIMEOUT_CYCLES - 1)) begin st_n = S_STOP; stat_n = 2'd2; end
        else wcnt_n = wcnt + CW'(1);
      end
      S_WB:    st_n = S_FETCH;
      default: st_n = S_STOP;
    endcase
  end

  // output decode for the state being entered
  always_comb begin
    rdy_n = 1'b0; we_e_n = 1'b0; we_m_n = 1'b0; as_n = 1'b0; bs_n = 1'b0;
    rd_n = 1'b0; wr_n = 1'b0; pw_n = 1'b0; ps_n = 1'b0; hlt_n = 1'b0;
    de_n = 4'hF; dm_n = 4'hF; fn_alu_n = 2'd0;
    case (st_n)
      S_FETCH: rdy_n = 1'b1;
      S_EXEC: case (ic_n)
        4'h2:       begin bs_n = 1'b1; fn_alu_n = 2'd3; end
        4'h3:       begin as_n = 1'b1; bs_n = 1'b1; fn_alu_n = 2'd3; end
        4'h4, 4'h5: as_n = 1'b1;
        4'h6:       fn_alu_n = fn_n[1:0];
        default:    ;
      endcase
      S_MEM: begin wr_n = (ic_n == 4'h4); rd_n = (ic_n == 4'h5); end
      S_WB: begin
        pw_n = 1'b1;
        case (ic_n)
          4'h2:       if (cnd_n) begin de_n = rb_n; we_e_n = 1'b1; end
          4'h3, 4'h6: begin de_n = rb_n; we_e_n = 1'b1; end
          4'h5:       begin dm_n = ra_n; we_m_n = 1'b1; end
          4'h7:       ps_n = cnd_n;
          default:    ;
        endcase
      end
      default: hlt_n = 1'b1;
    endcase
  end

  // state, latched fields and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st <= S_FETCH; ic_q <= 4'h0; fn_q <= 4'h0; cnd_q <= 1'b0; wcnt <= '0;
      srcA <= 4'h0; srcB <= 4'h0; cc <= 3'b100; stat <= 2'd0; halt <= 1'b0;
      instr_ready <= 1'b1; dstE <= 4'hF; dstM <= 4'hF; reg_we_e <= 1'b0; reg_we_m <= 1'b0;
      aluASelect <= 1'b0; aluBSelect <= 1'b0; alufun <= 2'd0;
      mem_rd <= 1'b0; mem_wr <= 1'b0; pc_we <= 1'b0; pc_sel <= 1'b0;
    end else begin
      st <= st_n; ic_q <= ic_n; fn_q <= fn_n; cnd_q <= cnd_n; wcnt <= wcnt_n;
      srcA <= ra_n; srcB <= rb_n; cc <= cc_n; stat <= stat_n; halt <= hlt_n;
      instr_ready <= rdy_n; dstE <= de_n; dstM <= dm_n; reg_we_e <= we_e_n; reg_we_m <= we_m_n;
      aluASelect <= as_n; aluBSelect <= bs_n; alufun <= fn_alu_n;
      mem_rd <= rd_n; mem_wr <= wr_n; pc_we <= pw_n; pc_sel <= ps_n;
    end
  end
endmodule

// File: tb/tb_y86_seq_controller.sv
// Cycle-level scoreboard bench for y86_seq_controller: the driver pushes the
// expected output vector for each cycle it drives; a negedge monitor pops it.
module tb_y86_seq_controller;
  localparam int TMO = 4;

  logic gclk = 1'b0;
  logic reset_n;
  logic [3:0] icode, ifun, rA, rB;
  logic instr_valid, instr_ready, alu_zf, alu_sf, alu_of, mem_ready;
  logic [3:0] srcA, srcB, dstE, dstM;
  logic reg_we_e, reg_we_m, aluASelect, aluBSelect, mem_rd, mem_wr, pc_we, pc_sel, halt;
  logic [1:0] alufun, stat;
  logic [2:0] cc;

  always #5 gclk = ~gclk;

  y86_seq_controller #(.ADDR_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(gclk), .reset_n(reset_n), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_of(alu_of), .mem_ready(mem_ready),
    .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
    .reg_we_e(reg_we_e), .reg_we_m(reg_we_m), .aluASelect(aluASelect), .aluBSelect(aluBSelect),
    .alufun(alufun), .mem_rd(mem_rd), .mem_wr(mem_wr), .pc_we(pc_we), .pc_sel(pc_sel),
    .cc(cc), .stat(stat), .halt(halt));

  typedef struct packed {
    logic rdy; logic [3:0] sa, sb, de, dm;
    logic we_e, we_m, as, bs; logic [1:0] fn;
    logic rd, wr, pw, ps; logic [2:0] cc; logic [1:0] st; logic hlt;
  } vec_t;

  vec_t  obs;
  vec_t  expq[$];
  string tagq[$];
  int    nvec = 0, nerr = 0;
  logic [3:0] m_sa, m_sb;
  logic [2:0] m_cc;

  assign obs = '{instr_ready, srcA, srcB, dstE, dstM, reg_we_e, reg_we_m, aluASelect,
                 aluBSelect, alufun, mem_rd, mem_wr, pc_we, pc_sel, cc, stat, halt};

  task automatic chk(input string tag, input vec_t o, input vec_t e);
    nvec++;
    if (o !== e) begin
      nerr++;
      $display("FAIL %s: got %h want %h (rdy,sa,sb,de,dm,we_e,we_m,as,bs,fn,rd,wr,pw,ps,cc,st,hlt)",
               tag, o, e);
    end
  endtask

  // monitor: compare one expected vector per cycle, away from the edge
  always @(negedge gclk)
    if (expq.size() > 0) chk(tagq.pop_front(), obs, expq.pop_front());

  function automatic vec_t idle();
    vec_t v = '0;
    v.sa = m_sa; v.sb = m_sb; v.de = 4'hF; v.dm = 4'hF; v.cc = m_cc;
    return v;
  endfunction

  function automatic logic cnd_of(input logic [3:0] f, input logic [2:0] c);
    case (f)
      4'd0: return 1'b1;
      4'd1: return (c[1] ^ c[0]) | c[2];
      4'd2: return c[1] ^ c[0];
      4'd3: return c[2];
      4'd4: return ~c[2];
      4'd5: return ~(c[1] ^ c[0]);
      4'd6: return ~(c[1] ^ c[0]) & ~c[2];
      default: return 1'b0;
    endcase
  endfunction

  task automatic push(input vec_t v, input string tag);
    expq.push_back(v); tagq.push_back(tag);
  endtask

  task automatic tick();
    @(posedge gclk); #1;
  endtask

  task automatic do_reset();
    vec_t v;
    instr_valid = 1'b0; mem_ready = 1'b0; reset_n = 1'b0;
    m_sa = 4'h0; m_sb = 4'h0; m_cc = 3'b100;
    v = idle(); v.rdy = 1'b1;
    push(v, "reset");
    tick();
    reset_n = 1'b1;
  endtask

  // absorbing stop: offer instructions that must be ignored
  task automatic stop(input logic [1:0] s, input string nm);
    vec_t v;
    for (int i = 0; i < 3; i++) begin
      instr_valid = 1'b1; icode = 4'h3; ifun = 4'h0; rA = 4'hF; rB = 4'h7;
      v = idle(); v.st = s; v.hlt = 1'b1;
      push(v, {nm, ":stop"});
      tick();
    end
    instr_valid = 1'b0;
  endtask

  // one instruction; waits<0 asserts reset in the second MEM cycle
  task automatic run(input logic [3:0] ic, fn, ra, rb, input logic [2:0] fl,
                     input int waits, input string nm);
    vec_t v; logic c; logic bad;
    instr_valid = 1'b1; icode = ic; ifun = fn; rA = ra; rB = rb;
    v = idle(); v.rdy = 1'b1;
    push(v, {nm, ":fetch"});
    tick();
    m_sa = ra; m_sb = rb;
    bad = (ic > 4'h7) || (ic == 4'h6 && fn > 3) || ((ic == 4'h2 || ic == 4'h7) && fn > 6) ||
          ((ic == 4'h3 || ic == 4'h4 || ic == 4'h5) && fn != 0);
    if (ic == 4'h0) begin stop(2'd1, nm); return; end
    if (bad)        begin stop(2'd3, nm); return; end
    // EXEC: a halt is offered here and must be ignored
    instr_valid = 1'b1; icode = 4'h0; ifun = 4'h0;
    {alu_zf, alu_sf, alu_of} = fl;
    v = idle();
    case (ic)
      4'h2: begin v.bs = 1; v.fn = 2'd3; end
      4'h3: begin v.as = 1; v.bs = 1; v.fn = 2'd3; end
      4'h4, 4'h5: v.as = 1;
      4'h6: v.fn = fn[1:0];
      default: ;
    endcase
    push(v, {nm, ":exec"});
    tick();
    c = cnd_of(fn, m_cc);
    if (ic == 4'h6) m_cc = fl;
    instr_valid = 1'b0;
    if (ic == 4'h4 || ic == 4'h5) begin
      for (int k = 0; ; k++) begin
        if (waits < 0 && k == 1) begin do_reset(); return; end
        mem_ready = (k == waits);
        v = idle(); v.wr = (ic == 4'h4); v.rd = (ic == 4'h5);
        push(v, {nm, ":mem"});
        tick();
        if (k == waits) break;
        if (k + 1 == TMO) begin mem_ready = 1'b0; stop(2'd2, nm); return; end
      end
      mem_ready = 1'b0;
    end
    v = idle(); v.pw = 1'b1;
    case (ic)
      4'h2: if (c) begin v.de = rb; v.we_e = 1; end
      4'h3, 4'h6: begin v.de = rb; v.we_e = 1; end
      4'h5: begin v.dm = ra; v.we_m = 1; end
      4'h7: v.ps = c;
      default: ;
    endcase
    push(v, {nm, ":wb"});
    tick();
  endtask

  initial begin
    reset_n = 1'b0; instr_valid = 1'b0; mem_ready = 1'b0;
    icode = 4'h0; ifun = 4'h0; rA = 4'h0; rB = 4'h0;
    {alu_zf, alu_sf, alu_of} = 3'b000;
    m_sa = 4'h0; m_sb = 4'h0; m_cc = 3'b100;
    tick();
    do_reset();
    run(4'h3, 4'h0, 4'hF, 4'h3, 3'b000, 0, "irmovl");
    run(4'h6, 4'h0, 4'h1, 4'h2, 3'b000, 0, "addl");
    run(4'h7, 4'h4, 4'hF, 4'hF, 3'b000, 0, "jne_t");
    run(4'h6, 4'h1, 4'h0, 4'h1, 3'b100, 0, "subl");
    run(4'h7, 4'h3, 4'hF, 4'hF, 3'b000, 0, "je");
    run(4'h7, 4'h4, 4'hF, 4'hF, 3'b000, 0, "jne");
    run(4'h2, 4'h4, 4'h1, 4'h5, 3'b000, 0, "cmovne");
    run(4'h2, 4'h1, 4'h1, 4'h6, 3'b000, 0, "cmovle");
    run(4'h5, 4'h0, 4'h2, 4'h4, 3'b000, 2, "mrmovl");
    run(4'h4, 4'h0, 4'h3, 4'h5, 3'b000, 0, "rmmovl");
    run(4'h1, 4'h0, 4'hF, 4'hF, 3'b000, 0, "nop");
    run(4'h6, 4'h3, 4'h6, 4'h7, 3'b011, 0, "xorl");
    run(4'h5, 4'h0, 4'h2, 4'h4, 3'b000, -1, "mrmovl_rst");
    run(4'h6, 4'h2, 4'h1, 4'h2, 3'b010, 0, "andl");
    run(4'h4, 4'h0, 4'h1, 4'h2, 3'b000, 99, "rmmovl_tmo");
    do_reset();
    run(4'h0, 4'h0, 4'h0, 4'h0, 3'b000, 0, "halt");
    do_reset();
    run(4'hC, 4'h0, 4'h0, 4'h0, 3'b000, 0, "icodeC");
    do_reset();
    run(4'h6, 4'h5, 4'h1, 4'h2, 3'b000, 0, "opl_f5");
    do_reset();
    run(4'h7, 4'h7, 4'hF, 4'hF, 3'b000, 0, "jxx_f7");
    do_reset();
    run(4'h3, 4'h1, 4'hF, 4'h2, 3'b000, 0, "irmovl_f1");
    tick();
    if (expq.size() != 0) begin
      nerr++;
      $display("FAIL drain: %0d expected vectors left, want 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
